// File: rtl/ro_puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF measurement engine.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        SETTLE,
        COMPARE,
        OUTPUT
    } state_t;

    localparam int NUM_RO_DEF = 16;
    localparam int CNT_W_DEF  = 12;
    localparam int WINDOW_DEF = 4095;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Saturating edge counter clocked by a ring oscillator; the enable is resynchronised
// into the RO domain so counting starts and stops on clean RO edges.
module ro_edge_counter #(
    parameter int CNT_W = 12
) (
    input  logic             roClk_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o
);

    logic             enMeta_q;
    logic             enSync_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Stick at all-ones so an overlong window reads as saturated rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (enSync_q && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge roClk_i or posedge clear_i) begin
        if (clear_i) begin
            enMeta_q <= 1'b0;
            enSync_q <= 1'b0;
            count_q  <= '0;
        end else begin
            enMeta_q <= enable_i;
            enSync_q <= enMeta_q;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF measurement engine: sequences clear/measure/settle windows per RO
// pair and assembles the comparison bits into a valid/ready response.
module ro_puf_engine
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO        = NUM_RO_DEF,
    parameter int SEL_W         = clog2(NUM_RO),
    parameter int CNT_W         = CNT_W_DEF,
    parameter int WINDOW        = WINDOW_DEF,
    parameter int CLR_CYCLES    = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int RESP_BITS     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     chal_a,
    input  logic [SEL_W-1:0]     chal_b,
    input  logic [NUM_RO-1:0]    ro_in,
    output logic                 ro_en,
    output logic                 ro_rst,
    output logic                 busy,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] response,
    output logic [CNT_W-1:0]     cnt_a_last,
    output logic [CNT_W-1:0]     cnt_b_last,
    output logic                 tie,
    output logic                 ovf
);

    localparam logic [15:0]      CLR_LAST = 16'(CLR_CYCLES - 1);
    localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);
    localparam logic [15:0]      SET_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] P_LAST   = SEL_W'(RESP_BITS - 1);
    localparam logic [SEL_W:0]   RO_COUNT = (SEL_W + 1)'(NUM_RO);

    state_t               state_q, state_d;
    logic [15:0]          timer_q, timer_d;
    logic                 mode_q, mode_d;
    logic [SEL_W-1:0]     chalA_q, chalA_d, chalB_q, chalB_d, p_q, p_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic                 tie_q, tie_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]     cntALast_q, cntALast_d, cntBLast_q, cntBLast_d;
    logic [CNT_W-1:0]     syncA1_q, syncA2_q, syncB1_q, syncB2_q;
    logic                 roRst_q, roEn_q;
    logic [SEL_W:0]       pInc;
    logic [SEL_W-1:0]     selA, selB;
    logic [CNT_W-1:0]     cntA, cntB;
    logic                 bitVal;

    // Sweep pairs each RO with its neighbour, wrapping the last one back to RO 0.
    assign pInc   = {1'b0, p_q} + 1'b1;
    assign selA   = mode_q ? p_q : chalA_q;
    assign selB   = mode_q ? ((pInc == RO_COUNT) ? '0 : pInc[SEL_W-1:0]) : chalB_q;
    assign bitVal = (syncA2_q > syncB2_q);

    ro_edge_counter #(.CNT_W(CNT_W)) uCntA (
        .roClk_i  (ro_in[selA]),
        .clear_i  (roRst_q),
        .enable_i (roEn_q),
        .count_o  (cntA)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) uCntB (
        .roClk_i  (ro_in[selB]),
        .clear_i  (roRst_q),
        .enable_i (roEn_q),
        .count_o  (cntB)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        mode_d     = mode_q;
        chalA_d    = chalA_q;
        chalB_d    = chalB_q;
        p_d        = p_q;
        resp_d     = resp_q;
        tie_d      = tie_q;
        ovf_d      = ovf_q;
        cntALast_d = cntALast_q;
        cntBLast_d = cntBLast_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    chalA_d = chal_a;
                    chalB_d = chal_b;
                    resp_d  = '0;
                    tie_d   = 1'b0;
                    ovf_d   = 1'b0;
                    p_d     = '0;
                    timer_d = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == CLR_LAST) begin
                    timer_d = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == WIN_LAST) begin
                    timer_d = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == SET_LAST) begin
                    timer_d = '0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                cntALast_d = syncA2_q;
                cntBLast_d = syncB2_q;
                if (syncA2_q == syncB2_q) begin
                    tie_d = 1'b1;
                end
                if ((syncA2_q == '1) || (syncB2_q == '1)) begin
                    ovf_d = 1'b1;
                end
                if (!mode_q) begin
                    resp_d    = '0;
                    resp_d[0] = bitVal;
                    state_d   = OUTPUT;
                end else begin
                    resp_d[p_q] = bitVal;
                    if (p_q == P_LAST) begin
                        state_d = OUTPUT;
                    end else begin
                        p_d     = p_q + 1'b1;
                        state_d = CLEAR;
                    end
                end
            end
            OUTPUT: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RO controls are registered from the next state so they change glitch-free with the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            mode_q     <= 1'b0;
            chalA_q    <= '0;
            chalB_q    <= '0;
            p_q        <= '0;
            resp_q     <= '0;
            tie_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cntALast_q <= '0;
            cntBLast_q <= '0;
            syncA1_q   <= '0;
            syncA2_q   <= '0;
            syncB1_q   <= '0;
            syncB2_q   <= '0;
            roRst_q    <= 1'b1;
            roEn_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            mode_q     <= mode_d;
            chalA_q    <= chalA_d;
            chalB_q    <= chalB_d;
            p_q        <= p_d;
            resp_q     <= resp_d;
            tie_q      <= tie_d;
            ovf_q      <= ovf_d;
            cntALast_q <= cntALast_d;
            cntBLast_q <= cntBLast_d;
            syncA1_q   <= cntA;
            syncA2_q   <= syncA1_q;
            syncB1_q   <= cntB;
            syncB2_q   <= syncB1_q;
            roRst_q    <= (state_d == IDLE) || (state_d == CLEAR);
            roEn_q     <= (state_d == MEASURE);
        end
    end

    assign ro_rst     = roRst_q;
    assign ro_en      = roEn_q;
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == OUTPUT);
    assign response   = resp_q;
    assign cnt_a_last = cntALast_q;
    assign cnt_b_last = cntBLast_q;
    assign tie        = tie_q;
    assign ovf        = ovf_q;

endmodule
